rsa_mont_param: RTL
===================

Name: rsa_mont_param

Overview:
- Precomputes the Montgomery constants for a modulus N: N_INV = -N^{-1} mod 2^WIDTH and R2_MOD_N = 2^(2*WIDTH) mod N.
- Sits directly upstream of the rsa / rsa_decrypt cores and feeds their N_INV and R2_MOD_N inputs, so software no longer computes them.
- Uses add/shift/compare datapaths only; no multiplier.

Parameters:
- WIDTH, 32, modulus width in bits (R = 2^WIDTH); WIDTH >= 4.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle request; sampled only in IDLE
- N  input  WIDTH  modulus; sampled on the start edge
- busy  output  1  high while a computation is in progress
- done  output  1  one-cycle pulse when results or err are valid
- err  output  1  N rejected (N even or N < 3); held until the next accepted start
- N_INV  output  WIDTH  -N^{-1} mod 2^WIDTH; held until the next accepted start
- R2_MOD_N  output  WIDTH  2^(2*WIDTH) mod N; held until the next accepted start

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy=0, done=0, err=0, N_INV=0, R2_MOD_N=0.
  - Applies mid-computation too: the operation is abandoned and no done pulse is issued.
- done defaults to 0 every cycle and is a one-cycle pulse only.
- State IDLE:
  - On start=1: latch n_r=N, clear err.
  - If N[0]==0 or N<3: next state ERR.
  - Otherwise: y=1, p=n_r (mod 2^WIDTH), i=1, r=1, k=0, busy<=1, next state INV.
- State ERR (1 cycle): err<=1, N_INV<=0, R2_MOD_N<=0, done<=1, busy<=0, next state IDLE.
  - done is high one cycle after the start edge.
- State INV (Hensel lifting), iteration i = 1..WIDTH-1, one per cycle:
  - If p[i]==1: y <= y | (1<<i); p <= p + (n_r<<i), truncated to WIDTH.
  - Invariant: n_r*y == p (mod 2^WIDTH), and p[i:0] == 1 after iteration i.
  - After i==WIDTH-1: next state SQR.
- State SQR (modular doubling), iteration k = 0..2*WIDTH-1, one per cycle:
  - t = {r,1'b0} computed at WIDTH+1 bits.
  - r <= (t >= n_r) ? t - n_r : t.
  - r stays < n_r, so WIDTH bits are sufficient after the subtract.
  - On k==2*WIDTH-1: R2_MOD_N <= next r; N_INV <= (~y)+1 (mod 2^WIDTH); done<=1; busy<=0; next state IDLE.
- Latency: start accepted at edge 0; done is high after edge 3*WIDTH-1, i.e. (WIDTH-1) INV cycles plus 2*WIDTH SQR cycles.
  - WIDTH=32 gives 95 cycles.
- start while busy=1 is ignored; n_r is not reloaded.
- start in the same cycle that done is asserted (state already IDLE on that edge) is accepted normally.
- Changes to N after the start edge have no effect.
- Output invariant on success: (N*N_INV) mod 2^WIDTH == 2^WIDTH-1.

Decomposition:
- Shared package rsa_pkg holds:
  - state enum {IDLE, INV, SQR, ERR}
  - localparam function LAT(W) = 3*W-1, also used by the bench.
- One sub-module is natural: mont_modinv2k, the INV-phase Hensel engine.
  - Ports: start, n, busy, done, inv.
  - Instanced by rsa_mont_param, which owns the SQR datapath and the FSM.

Test Plan:
- WIDTH=8, N=0xF1 -> after exactly 23 cycles done=1, N_INV=0xEF, R2_MOD_N=0xE1, err=0; busy low the same cycle.
- WIDTH=8, N=0x03 (minimum legal) -> N_INV=0x55, R2_MOD_N=0x01.
- WIDTH=32, N=0xFFFFFFFB -> N_INV=0xCCCCCCCD, R2_MOD_N=0x00000019, done at cycle 95.
  - Then chain these outputs into rsa with M=2, E=3 -> C=8.
- WIDTH=8, N=0x10 and N=0x01 -> done one cycle after start, err=1, N_INV=0, R2_MOD_N=0.
  - A following start with N=0xF1 clears err and produces the first scenario's values.
- WIDTH=8, N=0xF1 start; re-pulse start with N=0x03 at cycle 5 -> ignored, results for 0xF1 at cycle 23.
  - Then assert rst at cycle 10 of a new run -> no done pulse, all outputs 0.
- Random odd N, WIDTH=16, 200 runs -> N*N_INV mod 2^16 == 0xFFFF and R2_MOD_N == 2^32 mod N against the model.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types for the RSA Montgomery blocks.
// State encoding and the parameter-engine latency.
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INV,
    SQR,
    ERR
  } state_t;

  function automatic int LAT(input int w);
    return 3 * w - 1;
  endfunction

endpackage

// File: rtl/mont_modinv2k.sv
// Hensel-lifting inverse of an odd n modulo 2^WIDTH.
// One bit of the inverse is fixed per cycle, bits 1..WIDTH-1.
module mont_modinv2k
  import rsa_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] inv
);

  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] p;
  logic [IW-1:0]    i;

  // done flags the iteration that completes this cycle
  assign done = busy && (i == IW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      n_r  <= '0;
      p    <= '0;
      inv  <= '0;
      i    <= '0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      n_r  <= n;
      p    <= n;
      inv  <= WIDTH'(1);
      i    <= IW'(1);
    end else if (busy) begin
      if (p[i]) begin
        inv <= inv | (WIDTH'(1) << i);
        p   <= p + (n_r << i);
      end
      i <= i + IW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/rsa_mont_param.sv
// Montgomery constant generator: N_INV = -N^-1 mod 2^WIDTH
// and R2_MOD_N = 2^(2*WIDTH) mod N, shift/add/compare only.
module rsa_mont_param
  import rsa_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] N_INV,
  output logic [WIDTH-1:0] R2_MOD_N
);

  localparam int KW = $clog2(2 * WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_nx;
  logic [WIDTH:0]   t;
  logic [KW-1:0]    k;
  logic             n_ok;
  logic             go;
  logic             last;
  logic             inv_busy;
  logic             inv_done;
  logic [WIDTH-1:0] inv_y;

  assign n_ok = N[0] && (N >= WIDTH'(3));
  assign go   = (state == IDLE) && start;
  assign last = (state == SQR) && (k == KW'(2 * WIDTH - 1));

  mont_modinv2k #(
    .WIDTH(WIDTH)
  ) u_inv (
    .clk  (clk),
    .rst  (rst),
    .start(go && n_ok),
    .n    (N),
    .busy (inv_busy),
    .done (inv_done),
    .inv  (inv_y)
  );

  // r < n_r holds, so one conditional subtract keeps it reduced
  always_comb begin
    t    = {r, 1'b0};
    r_nx = t[WIDTH-1:0];
    if (t >= {1'b0, n_r}) begin
      r_nx = WIDTH'(t - {1'b0, n_r});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = n_ok ? INV : ERR;
      end
      INV: begin
        if (inv_done)      state_nx = SQR;
        else if (!inv_busy) state_nx = IDLE;
      end
      SQR: begin
        if (last) state_nx = IDLE;
      end
      ERR: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      N_INV    <= '0;
      R2_MOD_N <= '0;
      n_r      <= '0;
      r        <= '0;
      k        <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            n_r <= N;
            err <= 1'b0;
            if (n_ok) begin
              r    <= WIDTH'(1);
              k    <= '0;
              busy <= 1'b1;
            end
          end
        end
        SQR: begin
          r <= r_nx;
          k <= k + KW'(1);
          if (last) begin
            R2_MOD_N <= r_nx;
            N_INV    <= ~inv_y + WIDTH'(1);
            done     <= 1'b1;
            busy     <= 1'b0;
          end
        end
        ERR: begin
          err      <= 1'b1;
          N_INV    <= '0;
          R2_MOD_N <= '0;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
